// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares mainMem port a among requesters a, b and c.
// Round-robin or fixed-priority selection, registered issue stage to memory,
// registered one-cycle response back to the winner, saturating grant counters.

package mem_port_arbiter_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        MemWrite;
    logic        MemRead;
    logic        valid;
  } memReqStruct;

  typedef struct packed {
    logic [31:0] rd_data;
    logic        MemRead;
    logic        MemWrite;
    logic        valid;
  } memRespStruct;
endpackage

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  memReqStruct        req_a,
  input  memReqStruct        req_b,
  input  memReqStruct        req_c,
  output logic               gnt_a,
  output logic               gnt_b,
  output logic               gnt_c,
  output memRespStruct       resp_a,
  output memRespStruct       resp_b,
  output memRespStruct       resp_c,
  output memReqStruct        mem_req,
  input  memRespStruct       mem_resp,
  output logic [2:0]         illegal_sticky,
  output logic [CNT_W-1:0]   gnt_cnt_a,
  output logic [CNT_W-1:0]   gnt_cnt_b,
  output logic [CNT_W-1:0]   gnt_cnt_c
);

  typedef enum logic [1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    SEL_C = 2'd2
  } sel_e;

  typedef struct packed {
    memReqStruct req;
    sel_e        id;
    logic        illegal;
    logic        occ;
  } iss_t;

  sel_e                   last_q, last_d;
  iss_t                   iss_q, iss_d;
  memRespStruct [2:0]     resp_q, resp_d;
  logic [2:0]             sticky_q, sticky_d;
  logic [CNT_W-1:0]       cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]       cnt_b_q, cnt_b_d;
  logic [CNT_W-1:0]       cnt_c_q, cnt_c_d;

  logic [2:0]             vld;
  sel_e                   win_id;
  logic                   grant;
  logic [2:0]             win_oh;
  logic [2:0]             gnt_vec;
  memReqStruct            win_req;
  logic                   win_illegal;
  logic [2:0]             iss_oh;
  memRespStruct           rsp;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic g);
    return (g && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  // Pick the winner: fixed a > b > c, or round-robin starting after last_q.
  always_comb begin
    vld    = {req_c.valid, req_b.valid, req_a.valid};
    win_id = SEL_A;
    if (FIXED_PRIO != 0) begin
      if (vld[0])      win_id = SEL_A;
      else if (vld[1]) win_id = SEL_B;
      else             win_id = SEL_C;
    end else begin
      case (last_q)
        SEL_A: begin
          if (vld[1])      win_id = SEL_B;
          else if (vld[2]) win_id = SEL_C;
          else             win_id = SEL_A;
        end
        SEL_B: begin
          if (vld[2])      win_id = SEL_C;
          else if (vld[0]) win_id = SEL_A;
          else             win_id = SEL_B;
        end
        default: begin
          if (vld[0])      win_id = SEL_A;
          else if (vld[1]) win_id = SEL_B;
          else             win_id = SEL_C;
        end
      endcase
    end
    // Grants are held off while reset is asserted.
    grant   = (|vld) && reset;
    win_oh  = 3'b001 << win_id;
    gnt_vec = grant ? win_oh : 3'b000;
    case (win_id)
      SEL_A:   win_req = req_a;
      SEL_B:   win_req = req_b;
      default: win_req = req_c;
    endcase
    win_illegal = win_req.MemRead && win_req.MemWrite;
  end

  assign gnt_a = gnt_vec[0];
  assign gnt_b = gnt_vec[1];
  assign gnt_c = gnt_vec[2];

  // Next-state for issue stage, response stage, pointer, sticky flags, counters.
  always_comb begin
    iss_d = '0;
    if (grant) begin
      iss_d.req       = win_req;
      iss_d.req.valid = !win_illegal;
      iss_d.id        = win_id;
      iss_d.illegal   = win_illegal;
      iss_d.occ       = 1'b1;
    end

    // An illegal access still answers, but with zero data since memory never saw it.
    rsp         = '0;
    rsp.rd_data = iss_q.illegal ? 32'h0 : mem_resp.rd_data;
    rsp.MemRead = iss_q.req.MemRead;
    rsp.MemWrite = iss_q.req.MemWrite;
    rsp.valid   = 1'b1;
    iss_oh      = iss_q.occ ? (3'b001 << iss_q.id) : 3'b000;
    resp_d      = '0;
    resp_d[0]   = iss_oh[0] ? rsp : '0;
    resp_d[1]   = iss_oh[1] ? rsp : '0;
    resp_d[2]   = iss_oh[2] ? rsp : '0;

    last_d   = grant ? win_id : last_q;
    sticky_d = sticky_q | ((grant && win_illegal) ? win_oh : 3'b000);
    cnt_a_d  = sat_inc(cnt_a_q, gnt_vec[0]);
    cnt_b_d  = sat_inc(cnt_b_q, gnt_vec[1]);
    cnt_c_d  = sat_inc(cnt_c_q, gnt_vec[2]);
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q   <= SEL_C;
      iss_q    <= '0;
      resp_q   <= '0;
      sticky_q <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      cnt_c_q  <= '0;
    end else begin
      last_q   <= last_d;
      iss_q    <= iss_d;
      resp_q   <= resp_d;
      sticky_q <= sticky_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      cnt_c_q  <= cnt_c_d;
    end
  end

  assign mem_req        = iss_q.req;
  assign resp_a         = resp_q[0];
  assign resp_b         = resp_q[1];
  assign resp_c         = resp_q[2];
  assign illegal_sticky = sticky_q;
  assign gnt_cnt_a      = cnt_a_q;
  assign gnt_cnt_b      = cnt_b_q;
  assign gnt_cnt_c      = cnt_c_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed vectors push expected
// responses; a negedge monitor pops and compares them when they fall due.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  memReqStruct  req_a, req_b, req_c, mem_req, mem_req_fp;
  memRespStruct resp_a, resp_b, resp_c, mem_resp;
  memRespStruct resp_fp_a, resp_fp_b, resp_fp_c, mem_resp_fp;
  logic gnt_a, gnt_b, gnt_c, gnt_fp_a, gnt_fp_b, gnt_fp_c;
  logic [2:0]  ill, ill_fp;
  logic [3:0]  cnt_a, cnt_b, cnt_c;
  logic [15:0] cnt_fp_a, cnt_fp_b, cnt_fp_c;

  mem_port_arbiter #(.FIXED_PRIO(0), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .gnt_c(gnt_c),
    .resp_a(resp_a), .resp_b(resp_b), .resp_c(resp_c),
    .mem_req(mem_req), .mem_resp(mem_resp),
    .illegal_sticky(ill),
    .gnt_cnt_a(cnt_a), .gnt_cnt_b(cnt_b), .gnt_cnt_c(cnt_c)
  );

  mem_port_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .gnt_a(gnt_fp_a), .gnt_b(gnt_fp_b), .gnt_c(gnt_fp_c),
    .resp_a(resp_fp_a), .resp_b(resp_fp_b), .resp_c(resp_fp_c),
    .mem_req(mem_req_fp), .mem_resp(mem_resp_fp),
    .illegal_sticky(ill_fp),
    .gnt_cnt_a(cnt_fp_a), .gnt_cnt_b(cnt_fp_b), .gnt_cnt_c(cnt_fp_c)
  );

  // mainMem port a model: combinational read, write at end of issue cycle.
  logic [31:0] mem [0:63];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  always_comb begin
    mem_resp         = '0;
    mem_resp.rd_data = mem[mem_req.addr[7:2]];
    mem_resp.valid   = mem_req.valid;
  end
  always @(posedge clk) if (mem_req.valid && mem_req.MemWrite) mem[mem_req.addr[7:2]] <= mem_req.wr_data;
  assign mem_resp_fp = '0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned  id;
    memRespStruct rsp;
    int unsigned  due;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic memReqStruct mk(input logic [31:0] addr, input logic [31:0] data,
                                     input logic wr, input logic rd);
    memReqStruct r;
    r = '0;
    r.addr = addr; r.wr_data = data; r.MemWrite = wr; r.MemRead = rd; r.valid = 1'b1;
    return r;
  endfunction

  // Monitor: compare all three response ports every cycle against the scoreboard.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      mon_e = q.pop_front();
      check("resp_a", 64'(resp_a), (mon_e.id == 0) ? 64'(mon_e.rsp) : 64'h0);
      check("resp_b", 64'(resp_b), (mon_e.id == 1) ? 64'(mon_e.rsp) : 64'h0);
      check("resp_c", 64'(resp_c), (mon_e.id == 2) ? 64'(mon_e.rsp) : 64'h0);
    end else begin
      check("resp_idle", 64'({resp_c.valid, resp_b.valid, resp_a.valid}), 64'h0);
    end
  end

  task automatic apply(input memReqStruct ra, input memReqStruct rb, input memReqStruct rc,
                       input logic [2:0] eg, input logic [2:0] efp, input logic [31:0] edata);
    exp_t e;
    memReqStruct w;
    req_a = ra; req_b = rb; req_c = rc;
    @(negedge clk);
    check("gnt", 64'({gnt_c, gnt_b, gnt_a}), 64'(eg));
    check("gnt_fp", 64'({gnt_fp_c, gnt_fp_b, gnt_fp_a}), 64'(efp));
    if (eg != 3'b000) begin
      w = eg[0] ? ra : (eg[1] ? rb : rc);
      e.id = eg[0] ? 0 : (eg[1] ? 1 : 2);
      e.rsp = '0;
      e.rsp.rd_data  = edata;
      e.rsp.MemRead  = w.MemRead;
      e.rsp.MemWrite = w.MemWrite;
      e.rsp.valid    = 1'b1;
      e.due = cyc + 2;
      q.push_back(e);
    end
  endtask

  task automatic cyc_apply(input memReqStruct ra, input memReqStruct rb, input memReqStruct rc,
                           input logic [2:0] eg, input logic [2:0] efp, input logic [31:0] edata);
    @(posedge clk); #1;
    apply(ra, rb, rc, eg, efp, edata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_apply('0, '0, '0, 3'b000, 3'b000, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    req_a = '0; req_b = '0; req_c = '0;
    q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  memReqStruct ra4, rb0, rc4, none;

  initial begin
    none = '0;
    ra4  = mk(32'd4, 32'h0, 1'b0, 1'b1);
    rb0  = mk(32'd0, 32'h0, 1'b0, 1'b1);
    rc4  = mk(32'd4, 32'h0, 1'b0, 1'b1);
    req_a = ra4; req_b = '0; req_c = '0;

    // Reset state: outputs clear and grants held off despite a valid request.
    @(negedge clk); @(negedge clk);
    check("rst_gnt", 64'({gnt_c, gnt_b, gnt_a}), 64'h0);
    check("rst_gnt_fp", 64'({gnt_fp_c, gnt_fp_b, gnt_fp_a}), 64'h0);
    check("rst_mem_req", 64'(mem_req), 64'h0);
    check("rst_sticky", 64'(ill), 64'h0);
    check("rst_cnt", 64'({cnt_a, cnt_b, cnt_c}), 64'h0);

    // Write then read, first grant in the first cycle out of reset.
    @(posedge clk); #1;
    reset = 1'b1;
    apply(mk(32'd4, 32'hDEADBEEF, 1'b1, 1'b0), none, none, 3'b001, 3'b001, 32'h0);
    cyc_apply(none, mk(32'd4, 32'h0, 1'b0, 1'b1), none, 3'b010, 3'b010, 32'hDEADBEEF);
    idle(3);

    // Round-robin contention from reset.
    do_reset();
    apply(ra4, rb0, rc4, 3'b001, 3'b001, 32'hDEADBEEF);
    cyc_apply(ra4, rb0, rc4, 3'b010, 3'b001, 32'h0);
    cyc_apply(ra4, rb0, rc4, 3'b100, 3'b001, 32'hDEADBEEF);
    cyc_apply(ra4, rb0, rc4, 3'b001, 3'b001, 32'hDEADBEEF);
    cyc_apply(ra4, rb0, rc4, 3'b010, 3'b001, 32'h0);
    cyc_apply(ra4, rb0, rc4, 3'b100, 3'b001, 32'hDEADBEEF);
    cyc_apply(none, none, none, 3'b000, 3'b000, 32'h0);
    check("rr_cnt_a", 64'(cnt_a), 64'd2);
    check("rr_cnt_b", 64'(cnt_b), 64'd2);
    check("rr_cnt_c", 64'(cnt_c), 64'd2);
    check("fp_cnt_a", 64'(cnt_fp_a), 64'd6);
    check("fp_cnt_bc", 64'({cnt_fp_b, cnt_fp_c}), 64'h0);
    idle(2);

    // Fixed priority vs round-robin, then a drops and b wins.
    cyc_apply(ra4, rb0, rc4, 3'b001, 3'b001, 32'hDEADBEEF);
    cyc_apply(ra4, rb0, rc4, 3'b010, 3'b001, 32'h0);
    cyc_apply(ra4, rb0, rc4, 3'b100, 3'b001, 32'hDEADBEEF);
    cyc_apply(none, rb0, rc4, 3'b010, 3'b010, 32'h0);
    cyc_apply(none, none, rc4, 3'b100, 3'b100, 32'hDEADBEEF);
    idle(3);

    // Illegal request from c: granted, never reaches memory, answers with zero data.
    cyc_apply(none, none, mk(32'd4, 32'hFFFFFFFF, 1'b1, 1'b1), 3'b100, 3'b100, 32'h0);
    cyc_apply(none, none, none, 3'b000, 3'b000, 32'h0);
    check("ill_mem_valid", 64'(mem_req.valid), 64'h0);
    check("ill_mem_addr", 64'(mem_req.addr), 64'd4);
    check("ill_sticky", 64'(ill), 64'h4);
    cyc_apply(ra4, none, none, 3'b001, 3'b001, 32'hDEADBEEF);
    idle(3);

    // Reset during the issue cycle of a write discards it.
    cyc_apply(mk(32'd8, 32'h12345678, 1'b1, 1'b0), none, none, 3'b001, 3'b001, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_a = '0;
    q.delete();
    #1;
    check("midrst_mem_valid", 64'(mem_req.valid), 64'h0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    apply(none, none, none, 3'b000, 3'b000, 32'h0);
    check("midrst_cnt", 64'({cnt_a, cnt_b, cnt_c}), 64'h0);
    check("midrst_sticky", 64'(ill), 64'h0);
    cyc_apply(mk(32'd8, 32'h0, 1'b0, 1'b1), none, none, 3'b001, 3'b001, 32'h0);
    idle(3);

    // Counter saturation with a 4-bit counter.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cyc_apply(mk(32'd8, 32'h0, 1'b0, 1'b1), none, none, 3'b001, 3'b001, 32'h0);
      check("sat_cnt_a", 64'(cnt_a), (k - 1 > 15) ? 64'd15 : 64'(k - 1));
    end
    cyc_apply(none, none, none, 3'b000, 3'b000, 32'h0);
    check("sat_cnt_final", 64'(cnt_a), 64'd15);
    check("sat_cnt_fp16", 64'(cnt_fp_a), 64'd20);
    idle(3);

    check("sb_drain", 64'(q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Three-requester arbiter that shares port a of `mainMem` among requesters a, b and c. It accepts requests with a valid/grant handshake and selects one per cycle by round-robin or fixed priority. The winner goes through a registered issue stage to memory, and the read data comes back to the winning requester as a registered one-cycle response. It sits between the load/store and fetch-side clients and `mainMem`; the top level ties `mainMem` ports b and c to valid=0.

## Interface
- `FIXED_PRIO`, default 0: 0 = round-robin; 1 = fixed priority a > b > c.
- `CNT_W`, default 16: width of the per-requester saturating grant counters.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_a`, `req_b`, `req_c`  in  memReqStruct  requester requests (addr, wr_data, MemWrite, MemRead, valid).
- `gnt_a`, `gnt_b`, `gnt_c`  out  1  combinational accept, one-hot or zero.
- `resp_a`, `resp_b`, `resp_c`  out  memRespStruct  registered per-requester response.
- `mem_req`  out  memReqStruct  registered request to `mainMem` port a.
- `mem_resp`  in  memRespStruct  combinational response from `mainMem` port a.
- `illegal_sticky`  out  3  bit i is set when requester i presents MemRead && MemWrite.
- `gnt_cnt_a`, `gnt_cnt_b`, `gnt_cnt_c`  out  CNT_W  saturating grant counts.

## Operation
- **Handshake.** A requester raises `valid` and holds every request field stable until it sees its `gnt` high at a rising edge. The transfer happens on that edge. The requester may change or drop the request on the following cycle.
- **Eligibility.** Requester i is eligible when `valid` is high; legality is not checked.
- **Round-robin selection.** The `last` pointer is 2 bits, values 0/1/2 for a/b/c.
  - Search order starts at `last`+1 mod 3.
  - `last` updates to the winner only on a cycle with a grant.
  - Reset value of `last` is 2, so a has top priority after reset.
- **Fixed priority (`FIXED_PRIO`=1).** a > b > c; `last` is ignored.
- **Issue register.**
  - On a grant, capture the winner's request, its id, and an illegal flag (MemRead && MemWrite).
  - If the request is illegal, force `mem_req.valid` = 0 and set `illegal_sticky[id]`.
  - With no grant, the issue register's `valid` clears.
- **Response register.**
  - Loaded at the end of each issue cycle.
  - `resp_<id>` carries `mem_resp.rd_data`, plus MemRead/MemWrite echoed from the issue register, and `valid` = 1 for exactly one cycle.
  - An illegal request still produces a response: `valid` = 1, `rd_data` = 0.
  - Non-target `resp` outputs and all idle `resp` outputs are all-zero.
- **Grant counters.** `gnt_cnt_i` increments on each grant to i and saturates at 2^CNT_W-1.
- **Ordering.** Accesses are strictly in grant order. A read granted one cycle after a write to the same address returns the new data, because the write lands at the end of its issue cycle.
- **Reset values.** All registered state clears asynchronously when `reset` = 0:
  - `mem_req` = 0 and all `resp` = 0.
  - `illegal_sticky` = 0, all counters = 0, `last` = 2.
  - `gnt_*` are forced to 0 while `reset` = 0.

## Timing
- **Cycle N:** `req_x.valid` = 1 and x wins, so `gnt_x` = 1 combinationally in cycle N.
- **Cycle N+1:** `mem_req` holds x's request with `valid` = 1. `mainMem` reads combinationally; a write commits at the end of N+1.
- **Cycle N+2:** `resp_x.valid` = 1 with `rd_data`.
- **Latency and throughput.** Grant-to-response latency is 2 cycles, and throughput is 1 access per cycle with no bubbles. There is no backpressure on responses: requesters must accept `resp` in the cycle it appears.
- **All requesters valid every cycle.** Round-robin grant sequence is a, b, c, a, …; fixed priority grants a every cycle.
- **Single requester valid.** It is granted every cycle regardless of `last`.
- **Reset asserted mid-flight.** In-flight issue and response entries are discarded and no response is produced. `mem_req.valid` drops asynchronously, so no write commits at the next edge.
- **Reset release.** Takes effect synchronously to `clk`. The first grant is possible in the first cycle with `reset` = 1.

## Test plan
- **Single write then read.** a writes 0xDEADBEEF to addr 4; b reads addr 4 in the next cycle.
  - Response: `resp_b.rd_data` = 0xDEADBEEF in the cycle after `resp_a.valid`.
  - Latency: each response arrives exactly 2 cycles after its grant.
- **Round-robin contention.** a, b and c all hold valid reads for 6 cycles after reset.
  - Grants: a, b, c, a, b, c.
  - Counters: `gnt_cnt_*` = 2 each.
- **Fixed priority.** `FIXED_PRIO`=1, a, b and c all valid.
  - `gnt_a` = 1 every cycle; b and c are never granted while a is valid.
  - When a drops, b wins.
- **Illegal request.** c presents MemRead = MemWrite = 1.
  - `gnt_c` = 1; `mem_req.valid` = 0 in the next cycle.
  - `resp_c.valid` = 1 with `rd_data` = 0; `illegal_sticky` = 3'b100.
- **Reset mid-flight.**
  - Stimulus: assert `reset` = 0 in the issue cycle of a write of 0x12345678 to addr 8, then release it.
  - Response: no `resp`; a subsequent read of addr 8 returns 0; all counters are 0.
- **Counter saturation.** `CNT_W`=4, a alone is valid for 20 cycles: `gnt_cnt_a` stops at 15.
